fetch_pc_unit: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the branch target buffer.
- Owns the PC register and drives it to the BTB as cur_pc.
- Takes the BTB's pred_pc as the next fetch address and reloads from redirect_pc when a misprediction is flagged.
- Issues instruction-memory requests on the shared SRAM port and fills the IF/ID register, with stall and flush handling.

---
 rtl/fetch_pc_unit_pkg.sv | 17 +
 rtl/fetch_pc_unit_ifid.sv | 40 ++++
 rtl/fetch_pc_unit.sv | 157 +++++++++++++++
 tb/tb_fetch_pc_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// Shared fetch-stage types and defaults for the PC unit, BTB and ID.
// State encodings, reset PC and the bubble instruction live here.
package fetch_pc_unit_pkg;

  localparam int PC_W_DEF   = 16;
  localparam int INST_W_DEF = 16;

  localparam logic [15:0] RESET_PC_DEF = 16'h0000;
  localparam logic [15:0] NOP_INST_DEF = 16'h0800;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } fetchState_e;

endpackage

// File: rtl/fetch_pc_unit_ifid.sv
// IF/ID pipeline register: flush beats load, otherwise hold.
// Flush only bubbles valid/inst; pc and pred_pc keep their last values.
module if_id_reg
  import fetch_pc_unit_pkg::*;
#(
  parameter int PC_W = PC_W_DEF,
  parameter int INST_W = INST_W_DEF,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              flush,
  input  logic [PC_W-1:0]   inPc,
  input  logic [INST_W-1:0] inInst,
  input  logic [PC_W-1:0]   inPred,
  output logic              valid,
  output logic [PC_W-1:0]   pc,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   predPc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid  <= 1'b0;
      pc     <= '0;
      inst   <= NOP_INST;
      predPc <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      inst  <= NOP_INST;
    end else if (load) begin
      valid  <= 1'b1;
      pc     <= inPc;
      inst   <= inInst;
      predPc <= inPred;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: PC register, SRAM request FSM, hold buffer, IF/ID fill.
// Define FETCH_PERF_CNT_EN to add redirect / memory-wait counters.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int PC_W = PC_W_DEF,
  parameter int INST_W = INST_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF),
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   cur_pc,
  input  logic [PC_W-1:0]   pred_pc,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              stall,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ready,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              if_id_valid,
  output logic [PC_W-1:0]   if_id_pc,
  output logic [INST_W-1:0] if_id_inst,
  output logic [PC_W-1:0]   if_id_pred_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       perf_redirect_cnt,
  output logic [15:0]       perf_memwait_cnt
`endif
);

  fetchState_e       state;
  logic [PC_W-1:0]   pc;
  logic [INST_W-1:0] bufInst;
  logic [PC_W-1:0]   bufPred;
  logic [PC_W-1:0]   redirPc;

  logic              ifLoad;
  logic              ifFlush;
  logic [INST_W-1:0] ldInst;
  logic [PC_W-1:0]   ldPred;

  assign cur_pc    = pc;
  assign imem_addr = pc;
  assign imem_req  = rst && (state != S_HOLD);

  always_comb begin
    ifLoad  = 1'b0;
    ifFlush = 1'b0;
    ldInst  = imem_rdata;
    ldPred  = pred_pc;
    unique case (state)
      S_FETCH: begin
        if (redirect)
          ifFlush = 1'b1;
        else if (imem_ready && !stall)
          ifLoad = 1'b1;
        else if (!imem_ready && !stall)
          ifFlush = 1'b1;
      end
      S_HOLD: begin
        if (redirect) begin
          ifFlush = 1'b1;
        end else if (!stall) begin
          ifLoad = 1'b1;
          ldInst = bufInst;
          ldPred = bufPred;
        end
      end
      default: ifFlush = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      bufInst <= '0;
      bufPred <= '0;
      redirPc <= '0;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (redirect) begin
            if (imem_ready) begin
              pc <= redirect_pc;
            end else begin
              redirPc <= redirect_pc;
              state   <= S_DRAIN;
            end
          end else if (imem_ready) begin
            if (stall) begin
              bufInst <= imem_rdata;
              bufPred <= pred_pc;
              state   <= S_HOLD;
            end else begin
              pc <= pred_pc;
            end
          end
        end
        S_HOLD: begin
          if (redirect) begin
            pc    <= redirect_pc;
            state <= S_FETCH;
          end else if (!stall) begin
            pc    <= bufPred;
            state <= S_FETCH;
          end
        end
        S_DRAIN: begin
          // The old request must complete; its data is always dropped.
          if (imem_ready) begin
            pc    <= redirect ? redirect_pc : redirPc;
            state <= S_FETCH;
          end else if (redirect) begin
            redirPc <= redirect_pc;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  if_id_reg #(
    .PC_W    (PC_W),
    .INST_W  (INST_W),
    .NOP_INST(NOP_INST)
  ) u_if_id (
    .clk   (clk),
    .rst   (rst),
    .load  (ifLoad),
    .flush (ifFlush),
    .inPc  (pc),
    .inInst(ldInst),
    .inPred(ldPred),
    .valid (if_id_valid),
    .pc    (if_id_pc),
    .inst  (if_id_inst),
    .predPc(if_id_pred_pc)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_redirect_cnt <= '0;
      perf_memwait_cnt  <= '0;
    end else begin
      if (redirect && perf_redirect_cnt != 16'hFFFF)
        perf_redirect_cnt <= perf_redirect_cnt + 16'd1;
      if (imem_req && !imem_ready && perf_memwait_cnt != 16'hFFFF)
        perf_memwait_cnt <= perf_memwait_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed vector table, reset corners,
// then random traffic against a cycle-level behavioural model.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cur_pc, pred_pc, redirect_pc, imem_addr, imem_rdata;
  logic [15:0] if_id_pc, if_id_inst, if_id_pred_pc;
  logic        redirect, stall, imem_req, imem_ready, if_id_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_redirect_cnt, perf_memwait_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_pc_unit dut (
    .clk          (clk),
    .rst          (rst),
    .cur_pc       (cur_pc),
    .pred_pc      (pred_pc),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .if_id_valid  (if_id_valid),
    .if_id_pc     (if_id_pc),
    .if_id_inst   (if_id_inst),
    .if_id_pred_pc(if_id_pred_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_redirect_cnt(perf_redirect_cnt),
    .perf_memwait_cnt (perf_memwait_cnt)
`endif
  );

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] instOf(input logic [15:0] a);
    return a ^ 16'h5A00;
  endfunction

  typedef struct {
    logic        rdy;
    logic        stl;
    logic        red;
    logic [15:0] rpc;
    logic        ov;
    logic [15:0] pv;
    logic [15:0] ePc;
    logic        eReq;
    logic        eV;
    logic [15:0] eIfPc;
    logic [15:0] eIfPred;
  } vec_t;

  vec_t tbl[14];

  // model of architectural behaviour
  logic [15:0] mPc, mBufInst, mBufPred, mDrainTgt;
  logic        mHolding, mDraining;
  logic        mV;
  logic [15:0] mIfPc, mIfInst, mIfPred;
  int          mRedCnt, mWaitCnt;

  task automatic modelReset();
    mPc = 16'h0000; mHolding = 0; mDraining = 0;
    mBufInst = 0; mBufPred = 0; mDrainTgt = 0;
    mV = 0; mIfPc = 0; mIfInst = 16'h0800; mIfPred = 0;
    mRedCnt = 0; mWaitCnt = 0;
  endtask

  task automatic bubble();
    mV = 0;
    mIfInst = 16'h0800;
  endtask

  task automatic modelStep();
    if (!mHolding && !imem_ready) mWaitCnt++;
    if (redirect) begin
      mRedCnt++;
      bubble();
      if (mHolding) begin
        mHolding = 0;
        mPc = redirect_pc;
      end else if (imem_ready) begin
        mDraining = 0;
        mPc = redirect_pc;
      end else begin
        mDraining = 1;
        mDrainTgt = redirect_pc;
      end
    end else if (mHolding) begin
      if (!stall) begin
        mV = 1; mIfPc = mPc; mIfInst = mBufInst; mIfPred = mBufPred;
        mPc = mBufPred;
        mHolding = 0;
      end
    end else if (mDraining) begin
      bubble();
      if (imem_ready) begin
        mPc = mDrainTgt;
        mDraining = 0;
      end
    end else if (imem_ready) begin
      if (stall) begin
        mHolding = 1; mBufInst = imem_rdata; mBufPred = pred_pc;
      end else begin
        mV = 1; mIfPc = mPc; mIfInst = imem_rdata; mIfPred = pred_pc;
        mPc = pred_pc;
      end
    end else if (!stall) begin
      bubble();
    end
  endtask

  task automatic setIn(input logic rdy, input logic stl, input logic red,
                       input logic [15:0] rpc, input logic ov,
                       input logic [15:0] pv);
    imem_ready  = rdy;
    stall       = stl;
    redirect    = red;
    redirect_pc = rpc;
    imem_rdata  = instOf(cur_pc);
    pred_pc     = ov ? pv : cur_pc + 16'd4;
  endtask

  initial begin
    rst = 1'b0;
    setIn(0, 0, 0, 0, 0, 0);
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'h0,  1'b0, 16'h0,   16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 16'h0,  1'b0, 16'h0,   16'h0004, 1'b1, 1'b1, 16'h0000, 16'h0004};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 16'h0,  1'b0, 16'h0,   16'h0008, 1'b1, 1'b1, 16'h0004, 16'h0008};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 16'h0,  1'b0, 16'h0,   16'h0008, 1'b0, 1'b1, 16'h0004, 16'h0008};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 16'h0,  1'b0, 16'h0,   16'h0008, 1'b0, 1'b1, 16'h0004, 16'h0008};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 16'h0,  1'b0, 16'h0,   16'h0008, 1'b0, 1'b1, 16'h0004, 16'h0008};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 16'h20, 1'b0, 16'h0,   16'h000C, 1'b1, 1'b1, 16'h0008, 16'h000C};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 16'h0,  1'b0, 16'h0,   16'h0020, 1'b1, 1'b0, 16'h0008, 16'h000C};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 16'h40, 1'b0, 16'h0,   16'h0020, 1'b1, 1'b0, 16'h0008, 16'h000C};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 16'h0,  1'b0, 16'h0,   16'h0020, 1'b1, 1'b0, 16'h0008, 16'h000C};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 16'h0,  1'b0, 16'h0,   16'h0020, 1'b1, 1'b0, 16'h0008, 16'h000C};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 16'h0,  1'b0, 16'h0,   16'h0040, 1'b1, 1'b0, 16'h0008, 16'h000C};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 16'h0,  1'b1, 16'h100, 16'h0044, 1'b1, 1'b1, 16'h0040, 16'h0044};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 16'h0,  1'b0, 16'h0,   16'h0100, 1'b1, 1'b1, 16'h0044, 16'h0100};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cur_pc", cur_pc, 16'h0000);
    chk("rst_req", {15'd0, imem_req}, 16'd0);
    chk("rst_valid", {15'd0, if_id_valid}, 16'd0);
    chk("rst_inst", if_id_inst, 16'h0800);
    chk("rst_ifpc", if_id_pc, 16'h0000);
    chk("rst_ifpred", if_id_pred_pc, 16'h0000);
    rst = 1'b1;
    #1 chk("rel_req", {15'd0, imem_req}, 16'd1);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      setIn(tbl[i].rdy, tbl[i].stl, tbl[i].red, tbl[i].rpc,
            tbl[i].ov, tbl[i].pv);
      #1;
      chk($sformatf("v%0d_cur_pc", i), cur_pc, tbl[i].ePc);
      chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].ePc);
      chk($sformatf("v%0d_req", i), {15'd0, imem_req}, {15'd0, tbl[i].eReq});
      chk($sformatf("v%0d_valid", i), {15'd0, if_id_valid}, {15'd0, tbl[i].eV});
      chk($sformatf("v%0d_ifpc", i), if_id_pc, tbl[i].eIfPc);
      chk($sformatf("v%0d_ifpred", i), if_id_pred_pc, tbl[i].eIfPred);
      chk($sformatf("v%0d_inst", i), if_id_inst,
          tbl[i].eV ? instOf(tbl[i].eIfPc) : 16'h0800);
    end

    // reset in the middle of a drain: pending response must be ignored
    @(negedge clk);
    setIn(0, 0, 1, 16'h0300, 0, 0);
    @(negedge clk);
    setIn(0, 0, 0, 0, 0, 0);
    #1 chk("drain_req", {15'd0, imem_req}, 16'd1);
    chk("drain_cur_pc", cur_pc, 16'h0104);
    chk("drain_valid", {15'd0, if_id_valid}, 16'd0);
    #1 rst = 1'b0;
    #1 chk("mid_rst_pc", cur_pc, 16'h0000);
    chk("mid_rst_req", {15'd0, imem_req}, 16'd0);
    chk("mid_rst_inst", if_id_inst, 16'h0800);
`ifdef FETCH_PERF_CNT_EN
    chk("mid_rst_redcnt", perf_redirect_cnt, 16'd0);
    chk("mid_rst_waitcnt", perf_memwait_cnt, 16'd0);
`endif
    imem_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    setIn(1, 0, 0, 0, 0, 0);
    #1 chk("post_rst_pc", cur_pc, 16'h0000);
    @(negedge clk);
    setIn(1, 0, 0, 0, 0, 0);
    #1 chk("post_rst_pc1", cur_pc, 16'h0004);
    chk("post_rst_ifpc", if_id_pc, 16'h0000);
    chk("post_rst_valid", {15'd0, if_id_valid}, 16'd1);

    // random traffic against the model
    @(negedge clk);
    rst = 1'b0;
    setIn(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    modelReset();
    for (int i = 0; i < 1500; i++) begin
      setIn($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2,
            $urandom_range(0, 99) < 8, 16'($urandom) & 16'hFFFE,
            $urandom_range(0, 3) == 0, 16'($urandom) & 16'hFFFE);
      imem_rdata = 16'($urandom);
      #1;
      chk("rnd_cur_pc", cur_pc, mPc);
      chk("rnd_addr", imem_addr, mPc);
      chk("rnd_req", {15'd0, imem_req}, {15'd0, !mHolding});
      chk("rnd_valid", {15'd0, if_id_valid}, {15'd0, mV});
      chk("rnd_inst", if_id_inst, mIfInst);
      if (mV) begin
        chk("rnd_ifpc", if_id_pc, mIfPc);
        chk("rnd_ifpred", if_id_pred_pc, mIfPred);
      end
      modelStep();
      @(negedge clk);
    end
`ifdef FETCH_PERF_CNT_EN
    chk("perf_redirect", perf_redirect_cnt, 16'(mRedCnt));
    chk("perf_memwait", perf_memwait_cnt, 16'(mWaitCnt));
    rst = 1'b0;
    #1 chk("perf_rst_red", perf_redirect_cnt, 16'd0);
    chk("perf_rst_wait", perf_memwait_cnt, 16'd0);
    rst = 1'b1;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
